// File: rtl/regfile_scoreboard.sv
// 32x32 register file with 1-cycle registered reads and a per-register pending-write scoreboard.
// Optional macro REGFILE_BYPASS_EN: write-first read ports and a stall release on the retiring write.
module regfile_scoreboard #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [4:0]        rs_addr,
    input  logic [4:0]        rt_addr,
    output logic [DATA_W-1:0] rs_data,
    output logic [DATA_W-1:0] rt_data,
    input  logic              wr_en,
    input  logic [4:0]        wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              issue_valid,
    input  logic              issue_rwe,
    input  logic [4:0]        issue_dst,
    output logic              stall,
    output logic              sb_err
);

    logic [DATA_W-1:0] regs_q [32];
    logic [1:0]        cnt_q  [32];
    logic [1:0]        cnt_d  [32];
    logic [DATA_W-1:0] rs_data_q, rs_data_d;
    logic [DATA_W-1:0] rt_data_q, rt_data_d;
    logic              sb_err_q, sb_err_d;

    logic dec, inc;
    logic rs_busy, rt_busy, dst_full;

    assign dec = wr_en && (wr_addr != 5'd0);
    assign inc = issue_valid && issue_rwe && !stall && (issue_dst != 5'd0);

    always_comb begin
        rs_busy  = (rs_addr != 5'd0) && (cnt_q[rs_addr] != 2'd0);
        rt_busy  = (rt_addr != 5'd0) && (cnt_q[rt_addr] != 2'd0);
`ifdef REGFILE_BYPASS_EN
        // The last outstanding write retiring this cycle is forwarded, so it no longer blocks.
        if (dec && (wr_addr == rs_addr) && (cnt_q[rs_addr] == 2'd1)) rs_busy = 1'b0;
        if (dec && (wr_addr == rt_addr) && (cnt_q[rt_addr] == 2'd1)) rt_busy = 1'b0;
`endif
        dst_full = issue_rwe && (cnt_q[issue_dst] == 2'd3);
        stall    = issue_valid && (rs_busy || rt_busy || dst_full);
    end

    always_comb begin
        sb_err_d = sb_err_q;
        for (int i = 0; i < 32; i++) begin
            cnt_d[i] = cnt_q[i];
        end
        if (dec && (cnt_q[wr_addr] == 2'd0)) begin
            sb_err_d = 1'b1;
        end
        // A matching issue and writeback cancel out on the same register.
        if (inc && !(dec && (wr_addr == issue_dst))) begin
            cnt_d[issue_dst] = cnt_q[issue_dst] + 2'd1;
        end
        if (dec && !(inc && (wr_addr == issue_dst)) && (cnt_q[wr_addr] != 2'd0)) begin
            cnt_d[wr_addr] = cnt_q[wr_addr] - 2'd1;
        end
    end

    always_comb begin
        rs_data_d = regs_q[rs_addr];
        rt_data_d = regs_q[rt_addr];
`ifdef REGFILE_BYPASS_EN
        if (dec && (wr_addr == rs_addr)) rs_data_d = wr_data;
        if (dec && (wr_addr == rt_addr)) rt_data_d = wr_data;
`endif
        if (rs_addr == 5'd0) rs_data_d = '0;
        if (rt_addr == 5'd0) rt_data_d = '0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 32; i++) begin
                regs_q[i] <= '0;
                cnt_q[i]  <= 2'd0;
            end
            rs_data_q <= '0;
            rt_data_q <= '0;
            sb_err_q  <= 1'b0;
        end else begin
            if (dec) begin
                regs_q[wr_addr] <= wr_data;
            end
            for (int i = 0; i < 32; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            rs_data_q <= rs_data_d;
            rt_data_q <= rt_data_d;
            sb_err_q  <= sb_err_d;
        end
    end

    assign rs_data = rs_data_q;
    assign rt_data = rt_data_q;
    assign sb_err  = sb_err_q;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Scoreboard bench for regfile_scoreboard: driver pushes model predictions, monitor pops and compares.
module tb_regfile_scoreboard;

`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk;
    logic        reset_n;
    logic [4:0]  rs_addr, rt_addr, wr_addr, issue_dst;
    logic [31:0] rs_data, rt_data, wr_data;
    logic        wr_en, issue_valid, issue_rwe, stall, sb_err;

    regfile_scoreboard dut (
        .clk(clk), .reset_n(reset_n),
        .rs_addr(rs_addr), .rt_addr(rt_addr),
        .rs_data(rs_data), .rt_data(rt_data),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .issue_valid(issue_valid), .issue_rwe(issue_rwe), .issue_dst(issue_dst),
        .stall(stall), .sb_err(sb_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        stall;
        logic [31:0] rs;
        logic [31:0] rt;
        logic        err;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    logic [31:0] m_reg [32];
    int          m_pend[32];
    bit          m_err;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) begin
            m_reg[i]  = 32'h0;
            m_pend[i] = 0;
        end
        m_err = 1'b0;
    endtask

    // A source is blocked while any write to it is outstanding, unless the
    // bypass build sees its single outstanding write landing this cycle.
    function automatic bit src_blocked(input logic [4:0] a, input bit we, input logic [4:0] wa);
        if (a == 5'd0 || m_pend[a] == 0) return 1'b0;
        if (BYP && we && wa == a && m_pend[a] == 1) return 1'b0;
        return 1'b1;
    endfunction

    task automatic cyc(input bit iv, input bit rwe, input logic [4:0] dst,
                       input logic [4:0] rs, input logic [4:0] rt,
                       input bit we, input logic [4:0] wa, input logic [31:0] wd);
        exp_t e;
        bit   inc, dec;
        @(negedge clk);
        issue_valid = iv; issue_rwe = rwe; issue_dst = dst;
        rs_addr = rs; rt_addr = rt;
        wr_en = we; wr_addr = wa; wr_data = wd;
        e.stall = iv && (src_blocked(rs, we, wa) || src_blocked(rt, we, wa) ||
                         (rwe && m_pend[dst] == 3));
        e.rs = (rs == 5'd0) ? 32'h0 : ((BYP && we && wa == rs) ? wd : m_reg[rs]);
        e.rt = (rt == 5'd0) ? 32'h0 : ((BYP && we && wa == rt) ? wd : m_reg[rt]);
        inc = iv && rwe && !e.stall && dst != 5'd0;
        dec = we && wa != 5'd0;
        if (dec) begin
            if (m_pend[wa] == 0) m_err = 1'b1;
            m_reg[wa] = wd;
        end
        if (inc) m_pend[dst]++;
        if (dec && m_pend[wa] > 0) m_pend[wa]--;
        e.err = m_err;
        exp_q.push_back(e);
    endtask

    task automatic idle();
        cyc(0, 0, 5'd0, 5'd0, 5'd0, 0, 5'd0, 32'h0);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            #3;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("stall", {31'b0, stall}, {31'b0, e.stall});
                @(posedge clk);
                #1;
                chk("rs_data", rs_data, e.rs);
                chk("rt_data", rt_data, e.rt);
                chk("sb_err", {31'b0, sb_err}, {31'b0, e.err});
            end
        end
    end

    initial begin : driver
        logic [4:0] pend_list[$];
        reset_n = 1'b0;
        issue_valid = 0; issue_rwe = 0; issue_dst = 0;
        rs_addr = 0; rt_addr = 0; wr_en = 0; wr_addr = 0; wr_data = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("reset_rs", rs_data, 32'h0);
        chk("reset_rt", rt_data, 32'h0);
        chk("reset_err", {31'b0, sb_err}, 32'h0);
        chk("reset_stall", {31'b0, stall}, 32'h0);
        reset_n = 1'b1;

        // Write r5, read it back, then reset mid-cycle with a write and issue pending.
        cyc(1, 1, 5'd5, 5'd0, 5'd0, 0, 5'd0, 32'h0);
        cyc(0, 0, 5'd0, 5'd5, 5'd0, 1, 5'd5, 32'h1234);
        cyc(0, 0, 5'd0, 5'd5, 5'd5, 0, 5'd0, 32'h0);
        @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        chk("async_rst_rs", rs_data, 32'h0);
        chk("async_rst_rt", rt_data, 32'h0);
        issue_valid = 1; issue_rwe = 1; issue_dst = 5'd6;
        wr_en = 1; wr_addr = 5'd5; wr_data = 32'hDEAD;
        @(posedge clk);
        #1;
        chk("rst_edge_rs", rs_data, 32'h0);
        #1;
        reset_n = 1'b1;
        model_reset();
        cyc(1, 0, 5'd0, 5'd5, 5'd6, 0, 5'd0, 32'h0);
        cyc(1, 0, 5'd0, 5'd5, 5'd6, 0, 5'd0, 32'h0);

        // r0 is hardwired to zero and a write to it touches no counter.
        cyc(0, 0, 5'd0, 5'd0, 5'd0, 1, 5'd0, 32'hFFFF_FFFF);
        cyc(1, 0, 5'd0, 5'd0, 5'd0, 0, 5'd0, 32'h0);

        // RAW hazard on r8 resolved by its writeback.
        cyc(1, 1, 5'd8, 5'd0, 5'd0, 0, 5'd0, 32'h0);
        cyc(1, 0, 5'd0, 5'd8, 5'd0, 0, 5'd0, 32'h0);
        cyc(1, 0, 5'd0, 5'd8, 5'd0, 1, 5'd8, 32'hCAFE);
        cyc(1, 0, 5'd0, 5'd8, 5'd0, 0, 5'd0, 32'h0);

        // Counter saturation on r3.
        repeat (3) cyc(1, 1, 5'd3, 5'd0, 5'd0, 0, 5'd0, 32'h0);
        cyc(1, 1, 5'd3, 5'd0, 5'd0, 0, 5'd0, 32'h0);
        cyc(1, 1, 5'd3, 5'd0, 5'd0, 1, 5'd3, 32'h33);
        cyc(1, 1, 5'd3, 5'd0, 5'd0, 0, 5'd0, 32'h0);
        repeat (3) cyc(0, 0, 5'd0, 5'd3, 5'd0, 1, 5'd3, $urandom);

        // Simultaneous issue and writeback on r9 keeps its count at one.
        cyc(1, 1, 5'd9, 5'd0, 5'd0, 0, 5'd0, 32'h0);
        cyc(1, 1, 5'd9, 5'd0, 5'd0, 1, 5'd9, 32'h99);
        cyc(1, 0, 5'd0, 5'd9, 5'd0, 0, 5'd0, 32'h0);
        cyc(1, 0, 5'd0, 5'd0, 5'd9, 0, 5'd0, 32'h0);
        cyc(0, 0, 5'd0, 5'd9, 5'd0, 1, 5'd9, 32'h999);

        // Random traffic on a small register window; writebacks only retire pending writes.
        for (int n = 0; n < 600; n++) begin
            bit         we;
            logic [4:0] wa;
            pend_list.delete();
            for (int r = 1; r < 8; r++) if (m_pend[r] > 0) pend_list.push_back(5'(r));
            we = (pend_list.size() != 0) && ($urandom_range(0, 2) != 0);
            wa = we ? pend_list[$urandom_range(0, pend_list.size() - 1)] : 5'd0;
            cyc($urandom_range(0, 3) != 0, $urandom_range(0, 1), 5'($urandom_range(0, 7)),
                5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), we, wa, $urandom);
        end

        // Retire everything still outstanding.
        for (int r = 1; r < 32; r++) begin
            while (m_pend[r] > 0) cyc(1, 0, 5'd0, 5'(r), 5'd0, 1, 5'(r), $urandom);
        end

        // Underflow on r12 is sticky until reset.
        cyc(0, 0, 5'd0, 5'd12, 5'd0, 1, 5'd12, 32'h12);
        repeat (3) idle();
        repeat (2) @(posedge clk);
        #2;
        chk("err_held", {31'b0, sb_err}, 32'h1);
        reset_n = 1'b0;
        #1;
        chk("err_cleared", {31'b0, sb_err}, 32'h0);
        #1;
        reset_n = 1'b1;
        model_reset();
        idle();
        cyc(1, 0, 5'd0, 5'd12, 5'd0, 0, 5'd0, 32'h0);

        repeat (3) @(posedge clk);
        #2;
        chk("queue_drain", exp_q.size(), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/regfile_scoreboard.md
REGFILE_SCOREBOARD -- requirements
Module: regfile_scoreboard

Interface
REQ-001 clk  input  1  single clock; all state updates on rising edge.
REQ-002 reset_n  input  1  asynchronous, active-low reset.
REQ-003 rs_addr  input  5  read port A register index (insn[25:21] from decode).
REQ-004 rt_addr  input  5  read port B register index (insn[20:16] from decode).
REQ-005 rs_data  output  32  registered read data, port A.
REQ-006 rt_data  output  32  registered read data, port B.
REQ-007 wr_en  input  1  writeback register-write enable (rwe of writeback stage).
REQ-008 wr_addr  input  5  writeback destination index (rt or rd, per rdst).
REQ-009 wr_data  input  32  writeback data (ALU result or DMEM data, per rwd).
REQ-010 issue_valid  input  1  decode presents an instruction this cycle.
REQ-011 issue_rwe  input  1  issuing instruction will write a register.
REQ-012 issue_dst  input  5  issuing instruction's destination index.
REQ-013 stall  output  1  combinational; decode SHALL hold its instruction while high.
REQ-014 sb_err  output  1  sticky flag: writeback to a register with no pending write.

Function
REQ-015 Storage SHALL be 32 x 32-bit registers; r0 SHALL always read 0, and writes to r0 SHALL be ignored.
REQ-016 A write SHALL occur on the rising edge when wr_en=1 and wr_addr!=0.
REQ-017 Read latency SHALL be 1 cycle: rs_data/rt_data update every edge from rs_addr/rt_addr, independent of issue_valid and stall.
REQ-018 Each register SHALL have a 2-bit pending counter (0..3 outstanding writes).
REQ-019 inc condition: issue_valid=1, issue_rwe=1, stall=0, issue_dst!=0; counter[issue_dst] SHALL increment.
REQ-020 dec condition: wr_en=1, wr_addr!=0; counter[wr_addr] SHALL decrement.
REQ-021 inc and dec on the same register in the same cycle SHALL leave its counter unchanged.
REQ-022 dec on a counter at 0 SHALL leave it at 0 and set sb_err=1 until reset.
REQ-023 stall SHALL be 1 when issue_valid=1 and any of: counter[rs_addr]!=0 (rs_addr!=0); counter[rt_addr]!=0 (rt_addr!=0); issue_rwe=1 and counter[issue_dst]=3.
REQ-024 stall SHALL be 0 whenever issue_valid=0.
REQ-025 A stalled issue SHALL NOT modify any counter.

Reset
REQ-026 reset_n=0 SHALL immediately clear all 32 registers, all counters, rs_data, rt_data and sb_err to 0, regardless of clk.
REQ-027 A write or issue coinciding with reset assertion SHALL be discarded; the first update SHALL occur on the first rising edge with reset_n=1.

Configuration
REQ-028 Macro REGFILE_BYPASS_EN SHALL select the same-cycle write/read policy.
REQ-029 Defined: write-first -- when wr_en=1 and wr_addr equals a nonzero read address, that port SHALL capture wr_data; a source register whose counter is 1 and is being decremented this cycle SHALL NOT cause stall.
REQ-030 Undefined: read-first -- ports SHALL capture the pre-write register value; stall SHALL follow REQ-023 unmodified.

Verification
REQ-031 Reset: write r5=0x1234, pulse reset_n low mid-cycle -> rs_data=0 immediately; after release, reading r5 returns 0x00000000.
REQ-032 r0: wr_en=1, wr_addr=0, wr_data=0xFFFFFFFF; read r0 next cycle -> 0x00000000, no counter change, sb_err=0.
REQ-033 Hazard: issue dst=r8; next cycle issue with rs_addr=8 -> stall=1; wr_en=1, wr_addr=8, wr_data=0xCAFE -> stall=0 that cycle if REGFILE_BYPASS_EN, else next cycle; rs_data=0xCAFE.
REQ-034 Saturation: three unstalled issues to r3 -> fourth issue_dst=3 with issue_rwe=1 gives stall=1; one writeback to r3 -> stall=0.
REQ-035 Simultaneous: counter[r9]=1, same-cycle issue dst=r9 and writeback r9 -> counter remains 1, rs_addr=9 still stalls.
REQ-036 Underflow: writeback r12 with counter 0 -> sb_err=1, held until reset_n=0.
